// File: rtl/ita_package.sv
// Shared ITA types and sizes used by the output buffer and the controller.
package ita_package;

  localparam int unsigned N         = 16;
  localparam int unsigned WI        = 8;
  localparam int unsigned FifoDepth = 4;

  typedef enum logic [3:0] {
    Idle,
    Q,
    K,
    V,
    QK,
    AV,
    OW,
    F1,
    F2,
    MatMul
  } step_e;

  typedef logic [N-1:0][WI-1:0] oup_t;

  typedef struct packed {
    oup_t  data;
    step_e step;
    logic  last;
  } oup_entry_t;

endpackage

// File: rtl/ita_skid_reg.sv
// Valid/ready register pair: outputs come straight from flops and in_ready_o
// depends only on local state, so no ready-to-valid path crosses the stage.
module ita_skid_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             out_valid_q, skid_valid_q;
  logic [Width-1:0] out_data_q, skid_data_q;
  logic             in_fire, out_load;

  assign in_ready_o = !skid_valid_q;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_load   = !out_valid_q || out_ready_i;

  // Output register refills from the skid slot first, else from the input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
    end else if (clear_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) out_data_q <= in_data_i;
      end
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Skid slot payload is never reset; its valid bit guards it.
  always_ff @(posedge clk_i) begin
    if (in_fire && !out_load) skid_data_q <= in_data_i;
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/ita_output_fifo.sv
// Output buffer between requantizer and output port: circular FIFO of tagged
// result words. Define ITA_OUP_FIFO_REG_OUT_EN to register the head through a skid pair.
module ita_output_fifo
  import ita_package::*;
#(
  parameter int unsigned Depth = FifoDepth,
  parameter int unsigned DataW = N * WI
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [DataW-1:0]       data_i,
  input  step_e                  step_i,
  input  logic                   last_i,
  output logic                   oup_valid_o,
  input  logic                   oup_ready_i,
  output logic [DataW-1:0]       oup_data_o,
  output step_e                  oup_step_o,
  output logic                   oup_last_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  oup_entry_t      mem_q [Depth];
  oup_entry_t      wr_entry, head;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q, overflow_q;
  logic            pop, push_ok, push_drop, rd_adv;

  assign wr_entry  = '{data: data_i, step: step_i, last: last_i};
  assign pop       = oup_valid_o && oup_ready_i && !clear_i;
  assign push_ok   = push_i && !clear_i && (!full_q || pop);
  assign push_drop = push_i && !clear_i && full_q && !pop;
  assign count_d   = count_q + CntW'(push_ok) - CntW'(pop);

`ifdef ITA_OUP_FIFO_REG_OUT_EN
  // count_q spans storage plus the output stage; st_count_q is storage alone.
  logic [CntW-1:0]               st_count_q;
  logic                          st_valid, st_ready, st_rd;
  logic [$bits(oup_entry_t)-1:0] skid_out;

  assign st_valid = (st_count_q != '0);
  assign st_rd    = st_valid && st_ready && !clear_i;
  assign rd_adv   = st_rd;

  ita_skid_reg #(
    .Width($bits(oup_entry_t))
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_valid_i  (st_valid),
    .in_ready_o  (st_ready),
    .in_data_i   (mem_q[rptr_q]),
    .out_valid_o (oup_valid_o),
    .out_ready_i (oup_ready_i),
    .out_data_o  (skid_out)
  );

  assign head = oup_entry_t'(skid_out);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      st_count_q <= '0;
    else if (clear_i) st_count_q <= '0;
    else              st_count_q <= st_count_q + CntW'(push_ok) - CntW'(st_rd);
  end
`else
  // Head is muxed straight from storage; forced to zero while empty.
  assign rd_adv      = pop;
  assign oup_valid_o = !empty_q;
  assign head        = empty_q ? '0 : mem_q[rptr_q];
`endif

  assign oup_data_o = head.data;
  assign oup_step_o = head.step;
  assign oup_last_o = head.last;

  // Storage payload is not reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wr_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (rd_adv)  rptr_q <= rptr_q + PtrW'(1);
      count_q    <= count_d;
      full_q     <= (count_d == CntW'(Depth));
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_q || push_drop;
    end
  end

  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ita_output_fifo.sv
// Directed self-checking bench for ita_output_fifo (Depth = 4).
module tb_ita_output_fifo;
  import ita_package::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned DataW = N * WI;
  localparam int unsigned CntW  = $clog2(Depth) + 1;
`ifdef ITA_OUP_FIFO_REG_OUT_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  logic            push_i;
  logic [DataW-1:0] data_i;
  step_e           step_i;
  logic            last_i;
  logic            oup_valid_o;
  logic            oup_ready_i;
  logic [DataW-1:0] oup_data_o;
  step_e           oup_step_o;
  logic            oup_last_o;
  logic [CntW-1:0] count_o;
  logic            full_o, empty_o, overflow_o;

  always #5 clk_i = ~clk_i;

  ita_output_fifo #(.Depth(Depth), .DataW(DataW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (push_i),
    .data_i      (data_i),
    .step_i      (step_i),
    .last_i      (last_i),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_data_o  (oup_data_o),
    .oup_step_o  (oup_step_o),
    .oup_last_o  (oup_last_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .overflow_o  (overflow_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  oup_entry_t got_q[$];
  oup_entry_t exp_q[$];

  // Record each beat that will be accepted at the coming rising edge.
  always @(negedge clk_i) begin
    if (rst_ni && !clear_i && oup_valid_o && oup_ready_i)
      got_q.push_back({oup_data_o, oup_step_o, oup_last_o});
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive(input logic p, input logic [DataW-1:0] d, input step_e s, input logic l);
    push_i = p;
    data_i = d;
    step_i = s;
    last_i = l;
  endtask

  function automatic oup_entry_t mk(input logic [DataW-1:0] d, input step_e s, input logic l);
    return {d, s, l};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 160'(oup_valid_o), 160'(0));
    check({tag, "_data"},  160'(oup_data_o),  160'(0));
    check({tag, "_step"},  160'(oup_step_o),  160'(Idle));
    check({tag, "_last"},  160'(oup_last_o),  160'(0));
    check({tag, "_count"}, 160'(count_o),     160'(0));
    check({tag, "_full"},  160'(full_o),      160'(0));
    check({tag, "_empty"}, 160'(empty_o),     160'(1));
    check({tag, "_ovf"},   160'(overflow_o),  160'(0));
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_nbeats"}, 160'(got_q.size()), 160'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 160'(got_q[i]), 160'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  logic [DataW-1:0] d0, w, x;

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    oup_ready_i = 1'b0;
    drive(1'b0, '0, Idle, 1'b0);
    step_n(2);
    check_reset("rst");
    rst_ni = 1'b1;
    step_n(1);

    // Single push, ready held high
    d0 = 128'h0102030405060708090a0b0c0d0e0f10;
    oup_ready_i = 1'b1;
    drive(1'b1, d0, Q, 1'b1);
    step_n(1);
    drive(1'b0, '0, Idle, 1'b0);
    step_n(Lat - 1);
    check("single_valid", 160'(oup_valid_o), 160'(1));
    check("single_data",  160'(oup_data_o),  160'(d0));
    check("single_step",  160'(oup_step_o),  160'(Q));
    check("single_last",  160'(oup_last_o),  160'(1));
    step_n(1);
    check("single_count", 160'(count_o), 160'(0));
    check("single_empty", 160'(empty_o), 160'(1));
    exp_q.push_back(mk(d0, Q, 1'b1));
    check_beats("single");

    // Fill to full with ready low, then drain
    oup_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = {4{32'ha000_0000 + 32'(i)}};
      drive(1'b1, w, K, i == 3);
      exp_q.push_back(mk(w, K, i == 3));
      step_n(1);
    end
    drive(1'b0, '0, Idle, 1'b0);
    check("fill_count", 160'(count_o), 160'(4));
    check("fill_full",  160'(full_o),  160'(1));
    check("fill_empty", 160'(empty_o), 160'(0));
    oup_ready_i = 1'b1;
    step_n(4);
    check("drain_empty", 160'(empty_o), 160'(1));
    check("drain_count", 160'(count_o), 160'(0));
    check("drain_full",  160'(full_o),  160'(0));
    check_beats("drain");

    // Overflow: push into a full FIFO with no pop is dropped
    oup_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = {4{32'hb000_0000 + 32'(i)}};
      drive(1'b1, w, V, 1'b0);
      exp_q.push_back(mk(w, V, 1'b0));
      step_n(1);
    end
    x = {4{32'hdead_beef}};
    drive(1'b1, x, OW, 1'b1);
    step_n(1);
    drive(1'b0, '0, Idle, 1'b0);
    check("ovf_flag",  160'(overflow_o), 160'(1));
    check("ovf_count", 160'(count_o),    160'(4));
    oup_ready_i = 1'b1;
    step_n(4);
    check("ovf_sticky", 160'(overflow_o), 160'(1));
    check("ovf_count0", 160'(count_o),    160'(0));
    check_beats("ovf");

    // Clear with queued words plus a coincident push and pop
    oup_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, {4{32'hc000_0000 + 32'(i)}}, F1, 1'b0);
      step_n(1);
    end
    oup_ready_i = 1'b1;
    clear_i = 1'b1;
    drive(1'b1, {4{32'hcccc_cccc}}, F2, 1'b1);
    step_n(1);
    clear_i = 1'b0;
    drive(1'b0, '0, Idle, 1'b0);
    check("clr_ovf",   160'(overflow_o), 160'(0));
    check("clr_count", 160'(count_o),    160'(0));
    check("clr_empty", 160'(empty_o),    160'(1));
    step_n(3);
    check_beats("clr");

    // Full FIFO, push with a pop in the same cycle
    oup_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = {4{32'hd000_0000 + 32'(i)}};
      drive(1'b1, w, AV, 1'b0);
      exp_q.push_back(mk(w, AV, 1'b0));
      step_n(1);
    end
    w = {4{32'hd000_0004}};
    oup_ready_i = 1'b1;
    drive(1'b1, w, AV, 1'b1);
    exp_q.push_back(mk(w, AV, 1'b1));
    step_n(1);
    drive(1'b0, '0, Idle, 1'b0);
    check("pp_ovf",   160'(overflow_o), 160'(0));
    check("pp_count", 160'(count_o),    160'(4));
    step_n(4);
    check("pp_count0", 160'(count_o), 160'(0));
    check_beats("pp");

    // Sustained push and pop, occupancy held at 2
    oup_ready_i = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) oup_ready_i = 1'b1;
      w = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b1, w, MatMul, i[0]);
      exp_q.push_back(mk(w, MatMul, i[0]));
      step_n(1);
      if (i >= 2) check($sformatf("stream_count%0d", i), 160'(count_o), 160'(2));
    end
    drive(1'b0, '0, Idle, 1'b0);
    step_n(4);
    check("stream_count0", 160'(count_o), 160'(0));
    check_beats("stream");

    // Asynchronous reset with 3 entries queued
    oup_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {4{32'he000_0000 + 32'(i)}}, QK, 1'b1);
      step_n(1);
    end
    drive(1'b0, '0, Idle, 1'b0);
    check("mid_count", 160'(count_o), 160'(3));
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset("async");
    step_n(2);
    rst_ni = 1'b1;
    oup_ready_i = 1'b1;
    w = {4{32'hf00d_f00d}};
    drive(1'b1, w, K, 1'b1);
    exp_q.push_back(mk(w, K, 1'b1));
    step_n(1);
    drive(1'b0, '0, Idle, 1'b0);
    step_n(4);
    check("post_count", 160'(count_o), 160'(0));
    check_beats("post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
